// File: rtl/siaminer_pkg.sv
// Shared types and constants for the siaminer job scheduler.
// No timing or flow control of its own; consumed by nonce_sched and its interface.
package siaminer_pkg;

    localparam int NONCE_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic RES_MISS = 1'b0;
    localparam logic RES_HIT  = 1'b1;

endpackage

// File: rtl/nonce_sched_if.sv
// Work, pipeline-head and result signals of the nonce scheduler; valid/ready on work and result.
// Slave is the scheduler; master is the job source / pipeline / result consumer side.
interface nonce_sched_if
    import siaminer_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF
);
    logic               work_vld;
    logic               work_rdy;
    logic [NONCE_W-1:0] work_start;
    logic [NONCE_W-1:0] work_end;
    logic               abort;
    logic               vld_out;
    logic [NONCE_W-1:0] m04_out;
    logic               flush;
    logic               hit;
    logic [NONCE_W-1:0] hit_nonce;
    logic               res_vld;
    logic               res_hit;
    logic [NONCE_W-1:0] res_nonce;
    logic               res_ack;
    logic [NONCE_W-1:0] issue_cnt;

    modport master (
        output work_vld, work_start, work_end, abort, hit, hit_nonce, res_ack,
        input  work_rdy, vld_out, m04_out, flush, res_vld, res_hit, res_nonce, issue_cnt
    );

    modport slave (
        input  work_vld, work_start, work_end, abort, hit, hit_nonce, res_ack,
        output work_rdy, vld_out, m04_out, flush, res_vld, res_hit, res_nonce, issue_cnt
    );

endinterface

// File: rtl/nonce_gen.sv
// Current-nonce register with STEP increment and end-of-range detection; cur updates the cycle after load/adv.
// No flow control: the scheduler decides when to load and advance.
module nonce_gen
    import siaminer_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               adv,
    input  logic [NONCE_W-1:0] start,
    input  logic [NONCE_W-1:0] stop,
    output logic [NONCE_W-1:0] cur,
    output logic               last,
    output logic               empty
);

    localparam logic [NONCE_W:0] STEP_EXT = (NONCE_W + 1)'(STEP);

    logic [NONCE_W-1:0] range_end;
    logic [NONCE_W:0]   sum;

    assign sum   = {1'b0, cur} + STEP_EXT;
    // a carry out means the next nonce would wrap past the top of the space
    assign last  = sum[NONCE_W] | (sum[NONCE_W-1:0] > range_end);
    assign empty = start > stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= '0;
            range_end <= '0;
        end else if (load) begin
            cur       <= start;
            range_end <= stop;
        end else if (adv) begin
            cur <= sum[NONCE_W-1:0];
        end
    end

endmodule

// File: rtl/nonce_sched.sv
// Job controller: issues one nonce per cycle from the cycle after accept, drains DEPTH cycles, reports one result.
// Work accepted only in IDLE; the result is held with work_rdy low until res_ack.
module nonce_sched
    import siaminer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int STEP    = 1,
    parameter int NONCE_W = NONCE_W_DEF
) (
    input logic          clk,
    input logic          rst,
    nonce_sched_if.slave bus
);

    localparam int               DW         = $clog2(DEPTH + 1);
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DEPTH);
    localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
    localparam logic [NONCE_W-1:0] CNT_ONE  = NONCE_W'(1);

    state_t             state, state_nx;
    logic               vld_q, vld_nx;
    logic               flush_q, flush_nx;
    logic               res_vld_q, res_vld_nx;
    logic               res_hit_q, res_hit_nx;
    logic [NONCE_W-1:0] res_nonce_q, res_nonce_nx;
    logic [NONCE_W-1:0] issue_cnt_q, issue_cnt_nx;
    logic [DW-1:0]      drain_q, drain_nx;
    logic               gen_load, gen_adv, gen_last, range_empty;
    logic [NONCE_W-1:0] cur;

    nonce_gen #(
        .NONCE_W (NONCE_W),
        .STEP    (STEP)
    ) u_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (gen_load),
        .adv   (gen_adv),
        .start (bus.work_start),
        .stop  (bus.work_end),
        .cur   (cur),
        .last  (gen_last),
        .empty (range_empty)
    );

    always_comb begin
        state_nx     = state;
        vld_nx       = 1'b0;
        flush_nx     = 1'b0;
        res_vld_nx   = res_vld_q;
        res_hit_nx   = res_hit_q;
        res_nonce_nx = res_nonce_q;
        issue_cnt_nx = issue_cnt_q;
        drain_nx     = drain_q;
        gen_load     = 1'b0;
        gen_adv      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.work_vld) begin
                    gen_load     = 1'b1;
                    issue_cnt_nx = '0;
                    if (range_empty) begin
                        state_nx     = RESULT;
                        res_vld_nx   = 1'b1;
                        res_hit_nx   = RES_MISS;
                        res_nonce_nx = '0;
                    end else begin
                        // cur is loaded on this edge, so the first issue is the start nonce
                        state_nx     = RUN;
                        vld_nx       = 1'b1;
                        issue_cnt_nx = CNT_ONE;
                    end
                end
            end
            RUN, DRAIN: begin
                if (bus.hit) begin
                    state_nx     = RESULT;
                    flush_nx     = 1'b1;
                    res_vld_nx   = 1'b1;
                    res_hit_nx   = RES_HIT;
                    res_nonce_nx = bus.hit_nonce;
                end else if (bus.abort) begin
                    state_nx     = RESULT;
                    flush_nx     = 1'b1;
                    res_vld_nx   = 1'b1;
                    res_hit_nx   = RES_MISS;
                    res_nonce_nx = '0;
                end else if (state == RUN) begin
                    if (gen_last) begin
                        state_nx = DRAIN;
                        drain_nx = DRAIN_LOAD;
                    end else begin
                        gen_adv      = 1'b1;
                        vld_nx       = 1'b1;
                        issue_cnt_nx = issue_cnt_q + CNT_ONE;
                    end
                end else if (drain_q <= DRAIN_ONE) begin
                    state_nx     = RESULT;
                    drain_nx     = '0;
                    res_vld_nx   = 1'b1;
                    res_hit_nx   = RES_MISS;
                    res_nonce_nx = '0;
                end else begin
                    drain_nx = drain_q - DRAIN_ONE;
                end
            end
            RESULT: begin
                if (bus.res_ack) begin
                    state_nx     = IDLE;
                    res_vld_nx   = 1'b0;
                    res_hit_nx   = RES_MISS;
                    res_nonce_nx = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            vld_q       <= 1'b0;
            flush_q     <= 1'b0;
            res_vld_q   <= 1'b0;
            res_hit_q   <= RES_MISS;
            res_nonce_q <= '0;
            issue_cnt_q <= '0;
            drain_q     <= '0;
        end else begin
            state       <= state_nx;
            vld_q       <= vld_nx;
            flush_q     <= flush_nx;
            res_vld_q   <= res_vld_nx;
            res_hit_q   <= res_hit_nx;
            res_nonce_q <= res_nonce_nx;
            issue_cnt_q <= issue_cnt_nx;
            drain_q     <= drain_nx;
        end
    end

    assign bus.work_rdy  = (state == IDLE);
    assign bus.vld_out   = vld_q;
    assign bus.m04_out   = cur;
    assign bus.flush     = flush_q;
    assign bus.res_vld   = res_vld_q;
    assign bus.res_hit   = res_hit_q;
    assign bus.res_nonce = res_nonce_q;
    assign bus.issue_cnt = issue_cnt_q;

endmodule
